alu_pwr_sched: RTL
==================

Name: alu_pwr_sched

Overview:
- Two-requester scheduler in front of the power-gated 16-bit ALU.
- Round-robin arbitrates operation requests and sequences ALU power-up, isolation release, start, completion and response.
- Powers the ALU down (isolate first, then remove power) after an idle timeout.
- Sits between the two client datapaths and the ALU's alu_pwr_en/iso_en/start/busy interface.

Parameters:
- PWR_UP_CYCLES, 4, cycles alu_pwr_en is high with iso_en still asserted before isolation release (1..15).
- IDLE_TIMEOUT, 8, consecutive idle cycles in IDLE before power-down (1..255).
- WAIT_MAX, 31, maximum cycles in WAIT before a timeout error response (16..255).
- CLAMP_VAL, 16'h0000, value driven on alu_clamp_value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_opcode  in  4  ALU opcode.
- req0_a  in  16  operand A.
- req0_b  in  16  operand B.
- req0_ready  out  1  one-cycle accept pulse for requester 0.
- req1_valid, req1_opcode, req1_a, req1_b, req1_ready: same as above, for requester 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  16  result.
- rsp_err  out  1  illegal opcode or timeout.
- alu_pwr_en  out  1  ALU power enable.
- iso_en  out  1  ALU isolation enable.
- alu_start  out  1  one-cycle start.
- alu_opcode  out  4  ALU operands/opcode, held from accept until return to IDLE.
- alu_a  out  16  ALU operand A (held as above).
- alu_b  out  16  ALU operand B (held as above).
- alu_clamp_value  out  16  constant CLAMP_VAL.
- alu_result  in  16  ALU result.
- alu_busy  in  1  ALU busy.
- alu_on  out  1  high in IDLE/ISSUE/WAIT.

Behaviour:
- States: OFF, PWR_UP, IDLE, ISSUE, WAIT, PWR_DN.
- Reset (synchronous, wins over everything, including mid-operation):
  - State OFF; alu_pwr_en=0, iso_en=1.
  - alu_start, req*_ready, rsp_valid, rsp_err, rsp_id = 0; rsp_data=0; alu_opcode/a/b=0.
  - RR pointer favours requester 0; all counters 0.
- OFF: alu_pwr_en=0, iso_en=1. Any req*_valid -> PWR_UP. No request is accepted in OFF.
- PWR_UP: alu_pwr_en=1, iso_en=1 for exactly PWR_UP_CYCLES cycles, then IDLE.
- IDLE: alu_pwr_en=1, iso_en=0.
  - Arbitration: if any valid, grant per RR; with both valid, grant the requester not granted last. Pointer updates on every grant.
  - Grant cycle: pulse the winner's ready; latch opcode/a/b and id.
  - Opcode 0000..1001 -> ISSUE.
  - Opcode 1010..1111 -> no ALU access; next cycle rsp_valid=1, rsp_err=1, rsp_data=0; stay IDLE.
  - No valid: idle counter increments; at IDLE_TIMEOUT -> PWR_DN. Any grant clears the counter.
- ISSUE: alu_start=1 for one cycle -> WAIT.
- WAIT: first cycle where alu_busy=0 -> next cycle rsp_valid=1, rsp_data=alu_result, rsp_err=0, rsp_id=owner; state -> IDLE.
  - Timeout: if WAIT lasts WAIT_MAX cycles with busy high, respond rsp_err=1, rsp_data=0, then go to PWR_DN to reset the ALU.
- PWR_DN: iso_en=1 with alu_pwr_en=1 for one cycle, then OFF (alu_pwr_en=0).
  - Requests arriving during PWR_DN are not accepted; the power-down completes, then OFF sees valid and powers up again.
- Invariants:
  - iso_en=1 whenever alu_pwr_en=0.
  - alu_start only in ISSUE.
  - At most one request in flight.
  - req*_valid must stay high until ready; a requester may drop valid only after ready.
- Latency from grant cycle T:
  - Simple op: rsp_valid at T+3.
  - MUL: ALU busy T+2..T+6, rsp_valid at T+8.
  - DIV: busy T+2..T+10, rsp_valid at T+12.
  - A grant can recur in the same cycle as rsp_valid (back-to-back).

Test Plan:
- Cold start:
  - Stimulus: after reset, req0 ADD A=3 B=4.
  - Required: pwr_en rises; iso_en falls 4 cycles later; req0_ready pulses; rsp_valid 3 cycles after ready with rsp_data=7, rsp_id=0, rsp_err=0.
- Contention:
  - Stimulus: req0 and req1 both valid, each sending 3 SUBs.
  - Required: grants alternate 0,1,0,1,0,1; each rsp_id matches its grant; no overlapping starts.
- Multi-cycle ops:
  - Stimulus: MUL 300*5, then DIV 100/7, then DIV 5/0.
  - Required: rsp_data=1500 at T+8; 14 at T+12; 0 with rsp_err=0.
- Illegal opcode:
  - Stimulus: req1 opcode 4'b1100.
  - Required: alu_start never pulses; rsp_valid one cycle after ready with rsp_err=1, rsp_data=0.
- Idle power-down and re-wake:
  - Stimulus: no requests for 8 cycles in IDLE, then a request.
  - Required: iso_en=1 for one cycle before pwr_en=0; a request raised during PWR_DN is accepted only after the full OFF -> PWR_UP sequence.
- Reset and timeout:
  - Stimulus: assert rst_n=0 during MUL WAIT.
  - Required: next edge gives pwr_en=0, iso_en=1, no rsp_valid.
  - Stimulus: hold alu_busy=1 forced.
  - Required: rsp_err=1 after 31 WAIT cycles, followed by PWR_DN.

Source files
------------

// File: rtl/alu_pwr_sched.sv
// -----------------------------------------------------------------------------
// alu_pwr_sched
//
// Scheduler in front of a power-gated 16-bit ALU. Two requesters are
// round-robin arbitrated. The block sequences ALU power-up, isolation
// release, start, completion and response. After an idle timeout it powers
// the ALU down: isolation is applied first, then power is removed.
// Only one operation is in flight at any time.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   req{0,1}_valid              requester has an operation (held until ready)
//   req{0,1}_opcode/_a/_b       opcode and operands of that operation
//   req{0,1}_ready              one-cycle accept pulse to that requester
//   rsp_valid                   one-cycle response pulse
//   rsp_id                      requester that owns the response
//   rsp_data                    result (0 on error)
//   rsp_err                     illegal opcode or ALU timeout
//   alu_pwr_en, iso_en          ALU power enable / isolation enable
//   alu_start                   one-cycle start strobe to the ALU
//   alu_opcode/_a/_b            operation held from accept until back in IDLE
//   alu_clamp_value             isolation clamp value (constant CLAMP_VAL)
//   alu_result, alu_busy        ALU result and busy flag
//   alu_on                      ALU is powered and usable (IDLE/ISSUE/WAIT)
// -----------------------------------------------------------------------------
module alu_pwr_sched #(
    parameter int unsigned PWR_UP_CYCLES = 4,      // 1..15
    parameter int unsigned IDLE_TIMEOUT  = 8,      // 1..255
    parameter int unsigned WAIT_MAX      = 31,     // 16..255
    parameter logic [15:0] CLAMP_VAL     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [3:0]  req0_opcode,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [3:0]  req1_opcode,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,

    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,

    output logic        alu_pwr_en,
    output logic        iso_en,
    output logic        alu_start,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [15:0] alu_clamp_value,
    input  logic [15:0] alu_result,
    input  logic        alu_busy,
    output logic        alu_on
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_PWR_UP = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_PWR_DN = 3'd5;

    // Terminal counts: each counter starts at 0 on entry to its state.
    localparam logic [3:0] PU_LAST   = 4'(PWR_UP_CYCLES - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    logic [2:0]  state;
    logic [3:0]  pu_cnt;
    logic [7:0]  idle_cnt;
    logic [7:0]  wait_cnt;
    logic        last_gnt;   // requester granted most recently
    logic        owner;      // requester of the operation in flight

    logic        any_valid;
    logic        grant;
    logic        gnt_id;
    logic [3:0]  gnt_opcode;
    logic [15:0] gnt_a;
    logic [15:0] gnt_b;
    logic        gnt_illegal;

    // ---------------------------------------------------------------- arbiter
    assign any_valid = req0_valid | req1_valid;
    assign grant     = (state == S_IDLE) && any_valid;

    // With both requesting, the one not granted last wins; otherwise the
    // only requester wins.
    assign gnt_id = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;

    assign gnt_opcode  = gnt_id ? req1_opcode : req0_opcode;
    assign gnt_a       = gnt_id ? req1_a      : req0_a;
    assign gnt_b       = gnt_id ? req1_b      : req0_b;
    assign gnt_illegal = (gnt_opcode > 4'd9);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (grant) begin
            if (gnt_id) req1_ready = 1'b1;
            else        req0_ready = 1'b1;
        end
    end

    // ----------------------------------------------------------- power / ALU
    // Isolation is released only in the usable states, so iso_en is high
    // whenever alu_pwr_en is low.
    assign alu_on          = (state == S_IDLE) || (state == S_ISSUE) || (state == S_WAIT);
    assign alu_pwr_en      = (state != S_OFF);
    assign iso_en          = ~alu_on;
    assign alu_start       = (state == S_ISSUE);
    assign alu_clamp_value = CLAMP_VAL;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state      <= S_OFF;
            pu_cnt     <= '0;
            idle_cnt   <= '0;
            wait_cnt   <= '0;
            last_gnt   <= 1'b1;      // makes requester 0 win the first tie
            owner      <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            case (state)
                S_OFF: begin
                    pu_cnt <= '0;
                    if (any_valid) state <= S_PWR_UP;
                end

                S_PWR_UP: begin
                    if (pu_cnt == PU_LAST) begin
                        pu_cnt <= '0;
                        state  <= S_IDLE;
                    end else begin
                        pu_cnt <= pu_cnt + 4'd1;
                    end
                end

                S_IDLE: begin
                    if (any_valid) begin
                        idle_cnt   <= '0;
                        last_gnt   <= gnt_id;
                        owner      <= gnt_id;
                        alu_opcode <= gnt_opcode;
                        alu_a      <= gnt_a;
                        alu_b      <= gnt_b;
                        if (gnt_illegal) begin
                            // Rejected without touching the ALU; stay in IDLE.
                            rsp_valid <= 1'b1;
                            rsp_id    <= gnt_id;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_cnt <= '0;
                        state    <= S_PWR_DN;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end

                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (!alu_busy) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner;
                        rsp_data  <= alu_result;
                        rsp_err   <= 1'b0;
                        state     <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Hung ALU: report the error, then power-cycle it.
                        rsp_valid <= 1'b1;
                        rsp_id    <= owner;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= S_PWR_DN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_PWR_DN: begin
                    state <= S_OFF;
                end

                default: begin
                    state <= S_OFF;
                end
            endcase
        end
    end

endmodule
